imem_loader_server: RTL and testbench

Instruction-side responder for the pipelined CPU. It serves the CPU's combinational fetch, returning `instr` for a given `pc`. Before serving, it loads the program image from a byte-stream valid/ready channel into internal word RAM, holding the CPU in reset until the load finishes. It sits between the board-level program source and the CPU's `pc`/`instr` ports.

---
 rtl/imem_loader_server.sv | 137 +++++++++++++
 tb/tb_imem_loader_server.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_server.sv
// imem_loader_server
// Instruction memory for the CPU. It first loads a program image from a
// byte stream into word RAM, holding the CPU in reset during the load. It
// then answers fetches combinationally: instr follows pc in the same cycle.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   pc, instr   CPU fetch byte address / returned instruction (combinational)
//   ld_valid, ld_byte, ld_last, ld_ready
//               valid/ready byte stream of the image, big-endian words
//   cpu_rst     high while the image is loading
//   load_done   high once the image has been loaded (RUN)
//   word_count  number of words written to RAM
//   err_oob     sticky flag: image overflowed RAM, or a fetch was out of range
//   checksum    (IMEM_CHECKSUM_EN only) sum mod 2**32 of the words written
//
// Optional feature macro: IMEM_CHECKSUM_EN
module imem_loader_server #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pc,
    output logic [31:0]           instr,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  cpu_rst,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  err_oob
`ifdef IMEM_CHECKSUM_EN
    ,
    output logic [31:0]           checksum
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {LOAD, RUN} state_t;

    state_t      state, state_next;
    logic [1:0]  byte_idx;
    logic [31:0] asm_word;
    logic [31:0] word_next;
    logic [31:0] mem [DEPTH];
    logic        accept;
    logic        wr_word;
    logic        ram_full;
    logic        wr_en;
    logic        fetch_ok;
    logic [31:0] offset;

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        cpu_rst    = 1'b0;
        load_done  = 1'b0;
        accept     = 1'b0;
        case (state)
            LOAD: begin
                ld_ready = 1'b1;
                cpu_rst  = 1'b1;
                accept   = ld_valid;
                if (ld_valid && ld_last) state_next = RUN;
            end
            RUN: load_done = 1'b1;
            default: state_next = LOAD;
        endcase
    end

    // Current byte merged into the partial word; bytes not yet received stay
    // zero because asm_word is cleared after every word write.
    always_comb begin
        word_next = asm_word;
        case (byte_idx)
            2'd0:    word_next[31:24] = ld_byte;
            2'd1:    word_next[23:16] = ld_byte;
            2'd2:    word_next[15:8]  = ld_byte;
            default: word_next[7:0]   = ld_byte;
        endcase
    end

    assign wr_word  = accept && ((byte_idx == 2'd3) || ld_last);
    // word_count never exceeds DEPTH, so its MSB alone marks a full RAM.
    assign ram_full = word_count[ADDR_WIDTH];
    assign wr_en    = wr_word && !ram_full;

    assign offset   = pc - BASE_ADDR;
    assign fetch_ok = (pc >= BASE_ADDR) && (pc[1:0] == 2'b00) &&
                      ((offset >> 2) < {{(31 - ADDR_WIDTH){1'b0}}, word_count});
    assign instr    = (state == RUN && fetch_ok) ? mem[offset[ADDR_WIDTH+1:2]] : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx   <= 2'd0;
            asm_word   <= 32'h0;
            word_count <= '0;
            err_oob    <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            checksum   <= 32'h0;
`endif
        end else begin
            if (accept) begin
                if (wr_word) begin
                    asm_word <= 32'h0;
                    byte_idx <= 2'd0;
                    if (ram_full) begin
                        err_oob <= 1'b1;
                    end else begin
                        word_count <= word_count + 1'b1;
`ifdef IMEM_CHECKSUM_EN
                        checksum   <= checksum + word_next;
`endif
                    end
                end else begin
                    asm_word <= word_next;
                    byte_idx <= byte_idx + 2'd1;
                end
            end
            if (state == RUN && !fetch_ok) err_oob <= 1'b1;
        end
    end

    // RAM has no reset; a byte accepted on a reset edge is not written.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem[word_count[ADDR_WIDTH-1:0]] <= word_next;
    end

endmodule

// File: tb/tb_imem_loader_server.sv
module tb_imem_loader_server;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = BASE;
    logic [7:0]  ld_byte = 8'h00;
    logic        ld_last = 1'b0;
    logic        valid_a = 1'b0;
    logic        valid_b = 1'b0;

    logic [31:0] instr_a, instr_b;
    logic        ready_a, ready_b, cpu_rst_a, cpu_rst_b, done_a, done_b, err_a, err_b;
    logic [10:0] wc_a;
    logic [2:0]  wc_b;
`ifdef IMEM_CHECKSUM_EN
    logic [31:0] cs_a, cs_b;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imem_loader_server #(.ADDR_WIDTH(10), .BASE_ADDR(BASE)) dut_a (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr_a),
        .ld_valid(valid_a), .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ready_a),
        .cpu_rst(cpu_rst_a), .load_done(done_a), .word_count(wc_a), .err_oob(err_a)
`ifdef IMEM_CHECKSUM_EN
        , .checksum(cs_a)
`endif
    );

    imem_loader_server #(.ADDR_WIDTH(2), .BASE_ADDR(BASE)) dut_b (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr_b),
        .ld_valid(valid_b), .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ready_b),
        .cpu_rst(cpu_rst_b), .load_done(done_b), .word_count(wc_b), .err_oob(err_b)
`ifdef IMEM_CHECKSUM_EN
        , .checksum(cs_b)
`endif
    );

    task automatic send_byte(input logic [7:0] b, input logic last, input logic to_b);
        ld_byte = b;
        ld_last = last;
        if (to_b) valid_b = 1'b1;
        else      valid_a = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        ld_last = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic load_image1();
        logic [7:0] img [8];
        img = '{8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) send_byte(img[i], i == 7, 1'b0);
    endtask

    task automatic test_reset();
        pc = BASE;
        do_reset();
        checks++; if (cpu_rst_a !== 1'b1) begin failures++; $display("FAIL reset_cpu_rst got %b exp 1", cpu_rst_a); end
        checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL reset_ld_ready got %b exp 1", ready_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_load_done got %b exp 0", done_a); end
        checks++; if (wc_a !== 11'd0) begin failures++; $display("FAIL reset_word_count got %0d exp 0", wc_a); end
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL reset_err_oob got %b exp 0", err_a); end
        checks++; if (instr_a !== 32'h0) begin failures++; $display("FAIL reset_instr got %h exp 0", instr_a); end
        checks++; if (cpu_rst_b !== 1'b1 || wc_b !== 3'd0) begin failures++; $display("FAIL reset_b got cpu_rst=%b wc=%0d exp 1/0", cpu_rst_b, wc_b); end
    endtask

    task automatic test_basic_load();
        logic [7:0] img [7];
        img = '{8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        do_reset();
        for (int i = 0; i < 7; i++) send_byte(img[i], 1'b0, 1'b0);
        checks++; if (cpu_rst_a !== 1'b1 || wc_a !== 11'd1) begin failures++; $display("FAIL load_midway got cpu_rst=%b wc=%0d exp 1/1", cpu_rst_a, wc_a); end
        checks++; if (instr_a !== 32'h0) begin failures++; $display("FAIL load_instr_zero got %h exp 0", instr_a); end
        send_byte(8'h00, 1'b1, 1'b0);
        checks++; if (cpu_rst_a !== 1'b0) begin failures++; $display("FAIL load_cpu_rst_fall got %b exp 0", cpu_rst_a); end
        checks++; if (done_a !== 1'b1 || ready_a !== 1'b0) begin failures++; $display("FAIL load_run_flags got done=%b ready=%b exp 1/0", done_a, ready_a); end
        checks++; if (wc_a !== 11'd2) begin failures++; $display("FAIL load_word_count got %0d exp 2", wc_a); end
        pc = BASE; #1;
        checks++; if (instr_a !== 32'h2408_0005) begin failures++; $display("FAIL load_word0 got %h exp 24080005", instr_a); end
        pc = BASE + 32'd4; #1;
        checks++; if (instr_a !== 32'h0) begin failures++; $display("FAIL load_word1 got %h exp 0", instr_a); end
        pc = BASE;
        @(posedge clk); #1;
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL load_no_err got %b exp 0", err_a); end
    endtask

    task automatic test_partial_word();
        logic [7:0] img [6];
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(img[i], i == 5, 1'b0);
        checks++; if (wc_a !== 11'd2 || done_a !== 1'b1) begin failures++; $display("FAIL partial_state got wc=%0d done=%b exp 2/1", wc_a, done_a); end
        pc = BASE; #1;
        checks++; if (instr_a !== 32'hAABB_CCDD) begin failures++; $display("FAIL partial_word0 got %h exp aabbccdd", instr_a); end
        pc = BASE + 32'd4; #1;
        checks++; if (instr_a !== 32'h1122_0000) begin failures++; $display("FAIL partial_word1 got %h exp 11220000", instr_a); end
        pc = BASE;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch_errors();
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL fetch_err_before got %b exp 0", err_a); end
        pc = BASE + 32'd8; #1;
        checks++; if (instr_a !== 32'h0) begin failures++; $display("FAIL fetch_beyond got %h exp 0", instr_a); end
        @(posedge clk); #1;
        checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL fetch_err_set got %b exp 1", err_a); end
        pc = BASE + 32'd2; #1;
        checks++; if (instr_a !== 32'h0) begin failures++; $display("FAIL fetch_misaligned got %h exp 0", instr_a); end
        pc = 32'h003F_FFFC; #1;
        checks++; if (instr_a !== 32'h0) begin failures++; $display("FAIL fetch_below_base got %h exp 0", instr_a); end
        pc = BASE;
        @(posedge clk); #1;
        checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL fetch_err_sticky got %b exp 1", err_a); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b1);
        checks++; if (wc_b !== 3'd4 || err_b !== 1'b0 || done_b !== 1'b0) begin failures++; $display("FAIL ovf_full got wc=%0d err=%b done=%b exp 4/0/0", wc_b, err_b, done_b); end
        for (int i = 16; i < 20; i++) send_byte(8'(i), i == 19, 1'b1);
        checks++; if (wc_b !== 3'd4) begin failures++; $display("FAIL ovf_word_count got %0d exp 4", wc_b); end
        checks++; if (err_b !== 1'b1) begin failures++; $display("FAIL ovf_err got %b exp 1", err_b); end
        checks++; if (done_b !== 1'b1 || cpu_rst_b !== 1'b0) begin failures++; $display("FAIL ovf_run got done=%b cpu_rst=%b exp 1/0", done_b, cpu_rst_b); end
        pc = BASE + 32'd12; #1;
        checks++; if (instr_b !== 32'h0C0D_0E0F) begin failures++; $display("FAIL ovf_word3 got %h exp 0c0d0e0f", instr_b); end
        pc = BASE;
    endtask

    task automatic test_reset_midload();
        logic [7:0] img [5];
        img = '{8'h00, 8'h11, 8'h22, 8'h33, 8'hFF};
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(img[i], 1'b0, 1'b0);
        checks++; if (wc_a !== 11'd1 || cpu_rst_a !== 1'b1) begin failures++; $display("FAIL mid_before got wc=%0d cpu_rst=%b exp 1/1", wc_a, cpu_rst_a); end
        do_reset();
        checks++; if (wc_a !== 11'd0 || cpu_rst_a !== 1'b1 || ready_a !== 1'b1 || done_a !== 1'b0) begin
            failures++; $display("FAIL mid_after_rst got wc=%0d cpu_rst=%b ready=%b done=%b exp 0/1/1/0", wc_a, cpu_rst_a, ready_a, done_a);
        end
        load_image1();
        checks++; if (wc_a !== 11'd2 || done_a !== 1'b1) begin failures++; $display("FAIL mid_reload got wc=%0d done=%b exp 2/1", wc_a, done_a); end
        pc = BASE; #1;
        checks++; if (instr_a !== 32'h2408_0005) begin failures++; $display("FAIL mid_word0 got %h exp 24080005", instr_a); end
        pc = BASE + 32'd4; #1;
        checks++; if (instr_a !== 32'h0) begin failures++; $display("FAIL mid_word1 got %h exp 0", instr_a); end
        pc = BASE;
        @(posedge clk); #1;
    endtask

    task automatic test_run_ignores_loader();
`ifdef IMEM_CHECKSUM_EN
        checks++; if (cs_a !== 32'h2408_0005) begin failures++; $display("FAIL checksum got %h exp 24080005", cs_a); end
`endif
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hFF, 1'b1, 1'b0);
            checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL run_ready got %b exp 0", ready_a); end
            @(posedge clk); #1;
        end
        checks++; if (wc_a !== 11'd2 || done_a !== 1'b1) begin failures++; $display("FAIL run_state got wc=%0d done=%b exp 2/1", wc_a, done_a); end
        pc = BASE; #1;
        checks++; if (instr_a !== 32'h2408_0005) begin failures++; $display("FAIL run_word0 got %h exp 24080005", instr_a); end
        pc = BASE + 32'd4; #1;
        checks++; if (instr_a !== 32'h0) begin failures++; $display("FAIL run_word1 got %h exp 0", instr_a); end
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL run_err got %b exp 0", err_a); end
`ifdef IMEM_CHECKSUM_EN
        checks++; if (cs_a !== 32'h2408_0005) begin failures++; $display("FAIL checksum_hold got %h exp 24080005", cs_a); end
`endif
        pc = BASE;
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_basic_load();
        test_partial_word();
        test_fetch_errors();
        test_overflow();
        test_reset_midload();
        test_run_ignores_loader();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
